// File: rtl/snes_pad_reader.sv
// SNES controller reader: polls the pad at a fixed rate, shifts in 16 serial
// bits and presents them as a raw 12-bit button vector and an 8-bit core joystick.
module snes_pad_reader #(
  parameter int CLK_DIV     = 25,
  parameter int POLL_PERIOD = 69905
) (
  input  logic        clk,
  input  logic        reset,
  output logic        joy_strobe,
  output logic        joy_clock,
  input  logic        joy_data,
  output logic [7:0]  joystick,
  output logic [11:0] buttons,
  output logic        valid
);

  localparam int PW = $clog2(POLL_PERIOD);
  localparam logic [PW-1:0] POLL_LAST  = PW'(POLL_PERIOD - 1);
  localparam logic [8:0]    HALF_LAST  = 9'(CLK_DIV - 1);
  localparam logic [8:0]    LATCH_LAST = 9'(2 * CLK_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LATCH,
    S_HIGH,
    S_LOW,
    S_DONE
  } state_t;

  state_t          r_state;
  logic            r_sync1;
  logic            r_sync2;
  logic [PW-1:0]   r_poll;
  logic [3:0]      r_idx;
  logic [8:0]      r_phase;
  logic [11:0]     r_shift;

  logic            w_poll_wrap;
  logic            w_phase_half;
  logic            w_phase_latch;
  logic [7:0]      w_joy;

  assign w_poll_wrap   = (r_poll == POLL_LAST);
  assign w_phase_half  = (r_phase == HALF_LAST);
  assign w_phase_latch = (r_phase == LATCH_LAST);

  // r_shift holds pressed=1 in pad order; bits 12..15 of the stream are never stored.
  assign w_joy = {r_shift[3],
                  r_shift[2],
                  r_shift[0] | r_shift[1],
                  r_shift[8] | r_shift[9],
                  r_shift[5],
                  r_shift[4],
                  r_shift[6],
                  r_shift[7]};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= joy_data;
      r_sync2 <= r_sync1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_poll <= '0;
    end else if (w_poll_wrap) begin
      r_poll <= '0;
    end else begin
      r_poll <= r_poll + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_idx      <= '0;
      r_phase    <= '0;
      r_shift    <= '0;
      joy_strobe <= 1'b0;
      joy_clock  <= 1'b1;
      joystick   <= '0;
      buttons    <= '0;
      valid      <= 1'b0;
    end else begin
      valid <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          joy_strobe <= 1'b0;
          joy_clock  <= 1'b1;
          r_phase    <= '0;
          if (w_poll_wrap) begin
            joy_strobe <= 1'b1;
            r_state    <= S_LATCH;
          end
        end
        S_LATCH: begin
          if (w_phase_latch) begin
            r_phase    <= '0;
            r_idx      <= '0;
            joy_strobe <= 1'b0;
            r_state    <= S_HIGH;
          end else begin
            r_phase <= r_phase + 1'b1;
          end
        end
        S_HIGH: begin
          if (w_phase_half) begin
            if (r_idx < 4'd12) begin
              r_shift[r_idx] <= ~r_sync2;
            end
            r_phase   <= '0;
            joy_clock <= 1'b0;
            r_state   <= S_LOW;
          end else begin
            r_phase <= r_phase + 1'b1;
          end
        end
        S_LOW: begin
          if (w_phase_half) begin
            r_phase   <= '0;
            joy_clock <= 1'b1;
            if (r_idx == 4'd15) begin
              // Outputs load on entry to DONE so they appear together with valid.
              buttons  <= r_shift;
              joystick <= w_joy;
              valid    <= 1'b1;
              r_state  <= S_DONE;
            end else begin
              r_idx   <= r_idx + 1'b1;
              r_state <= S_HIGH;
            end
          end else begin
            r_phase <= r_phase + 1'b1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
